// File: rtl/if_fetch.sv
`default_nettype none
// ============================================================================
// Module   : if_fetch
// Purpose  : Instruction fetch stage. It drives a word-addressed PC into a
//            synchronous instruction ROM and registers the fetched word with
//            its own address. A decode stall is absorbed by a 1-entry skid
//            buffer. Branch redirects squash wrong-path words with a bubble.
// Config   : IF_PERF_CNT_EN - when defined, adds a saturating stall-cycle
//            counter on stall_cnt_o. When undefined, stall_cnt_o is tied to 0.
// Revision : 1.0 - initial release
// ============================================================================
module if_fetch #(
  parameter int                 W_INST = 32,
  parameter int                 W_PC   = 16,
  parameter logic [W_PC-1:0]    RST_PC = 16'h0000,
  parameter logic [W_INST-1:0]  BUBBLE = 32'hFE000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_i,
  input  logic              br_taken_i,
  input  logic [W_PC-1:0]   br_target_i,
  output logic              imem_req_o,
  output logic [W_PC-1:0]   imem_addr_o,
  input  logic [W_INST-1:0] imem_data_i,
  output logic [W_INST-1:0] inst_o,
  output logic [W_PC-1:0]   pc_value_o,
  output logic              valid_o,
  output logic [31:0]       stall_cnt_o
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_STALL    = 2'd1,
    ST_REDIRECT = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [W_PC-1:0]     pc_q, pc_d;
  logic [W_INST-1:0]   inst_q, inst_d;
  logic [W_PC-1:0]     pcv_q, pcv_d;
  logic                valid_q, valid_d;
  logic                skid_valid_q, skid_valid_d;
  logic [W_INST-1:0]   skid_inst_q, skid_inst_d;
  logic [W_PC-1:0]     skid_pc_q, skid_pc_d;
  logic                inflight_q, inflight_d;
  logic [W_PC-1:0]     inflight_pc_q, inflight_pc_d;
  logic                fetch;

  // Next-state logic: redirect beats stall; each ROM read carries its address as a tag.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    inst_d        = inst_q;
    pcv_d         = pcv_q;
    valid_d       = valid_q;
    skid_valid_d  = skid_valid_q;
    skid_inst_d   = skid_inst_q;
    skid_pc_d     = skid_pc_q;
    inflight_d    = inflight_q;
    inflight_pc_d = inflight_pc_q;
    fetch         = 1'b0;

    if (br_taken_i) begin
      // Any in-flight or buffered word is wrong-path; no read is issued this cycle.
      state_d      = ST_REDIRECT;
      pc_d         = br_target_i;
      inflight_d   = 1'b0;
      skid_valid_d = 1'b0;
      inst_d       = BUBBLE;
      valid_d      = 1'b0;
    end else begin
      case (state_q)
        ST_STALL: begin
          if (!stall_i) begin
            // The held word was accepted on this edge; replace it with the skid word or a bubble.
            if (skid_valid_q) begin
              inst_d  = skid_inst_q;
              pcv_d   = skid_pc_q;
              valid_d = 1'b1;
            end else begin
              inst_d  = BUBBLE;
              valid_d = 1'b0;
            end
            skid_valid_d = 1'b0;
            fetch        = 1'b1;
            state_d      = ST_RUN;
          end
        end
        default: begin
          // RUN and REDIRECT differ only in that REDIRECT never has a read in flight.
          if (stall_i) begin
            if (inflight_q) begin
              skid_valid_d = 1'b1;
              skid_inst_d  = imem_data_i;
              skid_pc_d    = inflight_pc_q;
            end
            inflight_d = 1'b0;
            state_d    = ST_STALL;
          end else begin
            if (inflight_q) begin
              inst_d  = imem_data_i;
              pcv_d   = inflight_pc_q;
              valid_d = 1'b1;
            end else begin
              inst_d  = BUBBLE;
              valid_d = 1'b0;
            end
            fetch   = 1'b1;
            state_d = ST_RUN;
          end
        end
      endcase

      if (fetch) begin
        pc_d          = pc_q + 1'b1;
        inflight_d    = 1'b1;
        inflight_pc_d = pc_q;
      end
    end
  end

  // ROM request is combinational so it drops in the same cycle the stall is seen.
  assign imem_req_o  = fetch & rst;
  assign imem_addr_o = pc_q;

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_RUN;
      pc_q          <= RST_PC;
      inst_q        <= BUBBLE;
      pcv_q         <= '0;
      valid_q       <= 1'b0;
      skid_valid_q  <= 1'b0;
      skid_inst_q   <= '0;
      skid_pc_q     <= '0;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      inst_q        <= inst_d;
      pcv_q         <= pcv_d;
      valid_q       <= valid_d;
      skid_valid_q  <= skid_valid_d;
      skid_inst_q   <= skid_inst_d;
      skid_pc_q     <= skid_pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
    end
  end

  assign inst_o     = inst_q;
  assign pc_value_o = pcv_q;
  assign valid_o    = valid_q;

`ifdef IF_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Saturating count of stalled cycles.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_i && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  // Counter register, cleared only by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= 32'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`else
  assign stall_cnt_o = 32'h0;
`endif

endmodule
`default_nettype wire
